// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle between the IF/MEM pipeline stages, the shared
// memory port and the arbiter that sequences them.
interface mem_port_arbiter_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   // instruction fetch side
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_valid;
   logic [DATA_W-1:0] if_rdata;
   // data access side
   logic              dm_read;
   logic              dm_write;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic              dm_valid;
   logic [DATA_W-1:0] dm_rdata;
   // shared memory port
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ready;
   logic [DATA_W-1:0] mem_rdata;

   // arbiter view
   modport master (
      input  if_req, if_addr, dm_read, dm_write, dm_addr, dm_wdata,
      input  mem_ready, mem_rdata,
      output if_valid, if_rdata, dm_valid, dm_rdata,
      output mem_req, mem_we, mem_addr, mem_wdata
   );

   // pipeline + memory view
   modport slave (
      output if_req, if_addr, dm_read, dm_write, dm_addr, dm_wdata,
      output mem_ready, mem_rdata,
      input  if_valid, if_rdata, dm_valid, dm_rdata,
      input  mem_req, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shared single-port memory arbiter: data access first, then instruction
// fetch; freezes the pipeline until both accesses of the cycle complete.
module mem_port_arbiter #(
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned MAX_WAIT = 64
) (
   input  logic                clk,
   input  logic                reset,
   mem_port_arbiter_if.master  bus,
   output logic                pc_hold,
   output logic [1:0]          if_id_regOption,
   output logic [1:0]          id_ex_regOption,
   output logic [1:0]          ex_mem_regOption,
   output logic [1:0]          mem_wb_regOption,
   output logic [31:0]         cnt_stall,
   output logic [31:0]         cnt_dm,
   output logic [31:0]         cnt_if,
   output logic                err_timeout
);

   localparam logic [1:0] OPT_NORMAL = 2'b00;
   localparam logic [1:0] OPT_FLUSH  = 2'b01;
   localparam logic [1:0] OPT_HOLD   = 2'b10;

   localparam int unsigned        WAIT_W   = $clog2(MAX_WAIT + 1);
   localparam logic [WAIT_W-1:0]  WAIT_LIM = WAIT_W'(MAX_WAIT);

   typedef enum logic {
      IDLE      = 1'b0,
      DM_SERVED = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] dm_buf_q, dm_buf_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              err_q, err_d;
   logic [31:0]       cnt_stall_q, cnt_stall_d;
   logic [31:0]       cnt_dm_q, cnt_dm_d;
   logic [31:0]       cnt_if_q, cnt_if_d;

   logic              dm_need, if_need, dm_done;
   logic              sel_dm, sel_if, hit_dm, hit_if;
   logic              rel, stall;
   logic [ADDR_W-1:0] addr_c;
   logic [DATA_W-1:0] wdata_c;

   // Arbitration and release decode; reset masks both requesters so the
   // port and the pipeline controls are quiet in a reset cycle.
   always_comb begin
      dm_need = (bus.dm_read | bus.dm_write) & ~reset;
      if_need = bus.if_req & ~reset;
      dm_done = (state_q == DM_SERVED);
      sel_dm  = dm_need & ~dm_done;
      sel_if  = ~sel_dm & if_need;
      hit_dm  = sel_dm & bus.mem_ready;
      hit_if  = sel_if & bus.mem_ready;
      rel     = (~dm_need | dm_done | hit_dm) & (~if_need | hit_if);
      stall   = ~rel;
   end

   // FSM next state: remember a data hit until the whole cycle releases.
   always_comb begin
      state_d = state_q;
      if (rel) begin
         state_d = IDLE;
      end else if (hit_dm) begin
         state_d = DM_SERVED;
      end
   end

   // Memory request mux and responses back to the pipeline.
   always_comb begin
      addr_c        = '0;
      wdata_c       = '0;
      bus.mem_we    = 1'b0;
      if (sel_dm) begin
         addr_c     = bus.dm_addr;
         wdata_c    = bus.dm_wdata;
         bus.mem_we = bus.dm_write;
      end else if (sel_if) begin
         addr_c     = bus.if_addr;
      end
      bus.mem_req   = sel_dm | sel_if;
      bus.mem_addr  = addr_c;
      bus.mem_wdata = wdata_c;
      bus.dm_rdata  = hit_dm ? bus.mem_rdata : dm_buf_q;
      bus.if_rdata  = hit_if ? bus.mem_rdata : '0;
      bus.dm_valid  = rel & dm_need;
      bus.if_valid  = rel & if_need;
   end

   // Pipeline freeze controls.
   always_comb begin
      pc_hold          = 1'b0;
      if_id_regOption  = OPT_NORMAL;
      id_ex_regOption  = OPT_NORMAL;
      ex_mem_regOption = OPT_NORMAL;
      mem_wb_regOption = OPT_NORMAL;
      if (stall) begin
         pc_hold          = 1'b1;
         if_id_regOption  = OPT_HOLD;
         id_ex_regOption  = OPT_HOLD;
         ex_mem_regOption = OPT_HOLD;
         mem_wb_regOption = OPT_FLUSH;
      end
   end

   // Next values for data buffer, counters and watchdog.
   always_comb begin
      dm_buf_d    = dm_buf_q;
      if (hit_dm & ~rel) begin
         dm_buf_d = bus.mem_rdata;
      end
      cnt_stall_d = cnt_stall_q + {31'd0, stall};
      cnt_dm_d    = cnt_dm_q + {31'd0, hit_dm};
      cnt_if_d    = cnt_if_q + {31'd0, hit_if};
      wait_d      = '0;
      if (bus.mem_req & ~bus.mem_ready) begin
         // saturates so a long hang cannot wrap back below the limit
         wait_d = (wait_q == WAIT_LIM) ? wait_q : wait_q + WAIT_W'(1);
      end
      err_d       = err_q | (wait_d == WAIT_LIM);
   end

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         dm_buf_q    <= '0;
         wait_q      <= '0;
         err_q       <= 1'b0;
         cnt_stall_q <= '0;
         cnt_dm_q    <= '0;
         cnt_if_q    <= '0;
      end else begin
         state_q     <= state_d;
         dm_buf_q    <= dm_buf_d;
         wait_q      <= wait_d;
         err_q       <= err_d;
         cnt_stall_q <= cnt_stall_d;
         cnt_dm_q    <= cnt_dm_d;
         cnt_if_q    <= cnt_if_d;
      end
   end

   assign cnt_stall   = cnt_stall_q;
   assign cnt_dm      = cnt_dm_q;
   assign cnt_if      = cnt_if_q;
   assign err_timeout = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a scoreboard of returned data.
module tb_mem_port_arbiter;

   logic        clk;
   logic        reset;
   logic        pc_hold;
   logic [1:0]  if_id_regOption, id_ex_regOption, ex_mem_regOption, mem_wb_regOption;
   logic [31:0] cnt_stall, cnt_dm, cnt_if;
   logic        err_timeout;

   int total;
   int bad;
   logic [31:0] exp_if_q[$];
   logic [31:0] exp_dm_q[$];
   int unsigned e_stall, e_dm, e_if;

   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4)) dut (
      .clk              (clk),
      .reset            (reset),
      .bus              (bus),
      .pc_hold          (pc_hold),
      .if_id_regOption  (if_id_regOption),
      .id_ex_regOption  (id_ex_regOption),
      .ex_mem_regOption (ex_mem_regOption),
      .mem_wb_regOption (mem_wb_regOption),
      .cnt_stall        (cnt_stall),
      .cnt_dm           (cnt_dm),
      .cnt_if           (cnt_if),
      .err_timeout      (err_timeout)
   );

   function automatic logic [31:0] mem_fn(input logic [31:0] a);
      return a ^ 32'h5A5A_0F0F;
   endfunction

   // memory returns an address-dependent word; mem_ready is driven by the steps
   assign bus.mem_rdata = mem_fn(bus.mem_addr);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic dr, input logic dw, input logic [31:0] da,
                        input logic [31:0] dwd, input logic ir, input logic [31:0] ia,
                        input logic rdy);
      bus.dm_read   = dr;
      bus.dm_write  = dw;
      bus.dm_addr   = da;
      bus.dm_wdata  = dwd;
      bus.if_req    = ir;
      bus.if_addr   = ia;
      bus.mem_ready = rdy;
   endtask

   // settle after the drive, then score any returned data
   task automatic probe();
      logic [31:0] e;
      #1;
      if (bus.if_valid) begin
         chk("if_pending", 32'(exp_if_q.size() != 0), 32'd1);
         if (exp_if_q.size() != 0) begin
            e = exp_if_q.pop_front();
            chk("if_rdata", bus.if_rdata, e);
         end
      end
      if (bus.dm_valid && bus.dm_read) begin
         chk("dm_pending", 32'(exp_dm_q.size() != 0), 32'd1);
         if (exp_dm_q.size() != 0) begin
            e = exp_dm_q.pop_front();
            chk("dm_rdata", bus.dm_rdata, e);
         end
      end
   endtask

   function automatic logic [31:0] opts();
      return {24'd0, if_id_regOption, id_ex_regOption, ex_mem_regOption, mem_wb_regOption};
   endfunction

   task automatic chk_counts(input string tag);
      chk({tag, "_stall"}, cnt_stall, e_stall);
      chk({tag, "_dm"}, cnt_dm, e_dm);
      chk({tag, "_if"}, cnt_if, e_if);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      e_stall = 0; e_dm = 0; e_if = 0;
      reset = 1'b1;
      drive(1'b0, 1'b0, '0, '0, 1'b1, 32'h0000_0040, 1'b1);
      @(negedge clk);
      @(negedge clk);
      // reset cycle with a pending fetch: port and controls stay quiet
      probe();
      chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
      chk("rst_pc_hold", 32'(pc_hold), 32'd0);
      chk("rst_opts", opts(), 32'h00);
      chk("rst_err", 32'(err_timeout), 32'd0);
      chk_counts("rst");

      // idle with mem_ready=1 and no request: ignored
      reset = 1'b0;
      drive(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1);
      @(negedge clk);
      probe();
      chk("idle_mem_req", 32'(bus.mem_req), 32'd0);
      chk("idle_addr", bus.mem_addr, 32'd0);
      chk("idle_valids", {30'd0, bus.if_valid, bus.dm_valid}, 32'd0);

      // zero-wait fetch only
      drive(1'b0, 1'b0, '0, '0, 1'b1, 32'h0000_0100, 1'b1);
      exp_if_q.push_back(mem_fn(32'h0000_0100));
      probe();
      chk("t1_mem_req", 32'(bus.mem_req), 32'd1);
      chk("t1_addr", bus.mem_addr, 32'h0000_0100);
      chk("t1_we", 32'(bus.mem_we), 32'd0);
      chk("t1_if_valid", 32'(bus.if_valid), 32'd1);
      chk("t1_pc_hold", 32'(pc_hold), 32'd0);
      chk("t1_opts", opts(), 32'h00);
      e_if = e_if + 1;
      @(negedge clk);
      drive(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1);
      chk_counts("t1");

      // zero-wait load plus fetch: one stall cycle
      drive(1'b1, 1'b0, 32'h0000_2000, 32'h1111_1111, 1'b1, 32'h0000_0104, 1'b1);
      exp_dm_q.push_back(mem_fn(32'h0000_2000));
      exp_if_q.push_back(mem_fn(32'h0000_0104));
      probe();
      chk("t2c0_addr", bus.mem_addr, 32'h0000_2000);
      chk("t2c0_we", 32'(bus.mem_we), 32'd0);
      chk("t2c0_pc_hold", 32'(pc_hold), 32'd1);
      chk("t2c0_opts", opts(), 32'hA9);
      chk("t2c0_valids", {30'd0, bus.if_valid, bus.dm_valid}, 32'd0);
      @(negedge clk);
      probe();
      chk("t2c1_addr", bus.mem_addr, 32'h0000_0104);
      chk("t2c1_valids", {30'd0, bus.if_valid, bus.dm_valid}, 32'd3);
      chk("t2c1_pc_hold", 32'(pc_hold), 32'd0);
      chk("t2c1_opts", opts(), 32'h00);
      e_stall = e_stall + 1; e_dm = e_dm + 1; e_if = e_if + 1;
      @(negedge clk);
      drive(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
      chk_counts("t2");

      // store ready after 3 waits, fetch ready after 2 waits: 6 stall cycles
      drive(1'b0, 1'b1, 32'h0000_3000, 32'hCAFE_F00D, 1'b1, 32'h0000_0108, 1'b0);
      exp_if_q.push_back(mem_fn(32'h0000_0108));
      for (int c = 0; c <= 6; c++) begin
         bus.mem_ready = (c == 3 || c == 6);
         probe();
         if (c <= 3) begin
            chk("t3_dm_we", 32'(bus.mem_we), 32'd1);
            chk("t3_dm_addr", bus.mem_addr, 32'h0000_3000);
            chk("t3_dm_wdata", bus.mem_wdata, 32'hCAFE_F00D);
         end else begin
            chk("t3_if_we", 32'(bus.mem_we), 32'd0);
            chk("t3_if_addr", bus.mem_addr, 32'h0000_0108);
            chk("t3_if_wdata", bus.mem_wdata, 32'd0);
         end
         chk("t3_pc_hold", 32'(pc_hold), 32'(c < 6));
         chk("t3_valids", {30'd0, bus.if_valid, bus.dm_valid}, (c == 6) ? 32'd3 : 32'd0);
         @(negedge clk);
      end
      e_stall = e_stall + 6; e_dm = e_dm + 1; e_if = e_if + 1;
      drive(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
      chk_counts("t3");
      chk("t3_err", 32'(err_timeout), 32'd0);

      // watchdog: four unanswered cycles set the sticky flag
      drive(1'b0, 1'b0, '0, '0, 1'b1, 32'h0000_0200, 1'b0);
      exp_if_q.push_back(mem_fn(32'h0000_0200));
      for (int c = 0; c <= 5; c++) begin
         bus.mem_ready = (c == 5);
         probe();
         chk("t4_err", 32'(err_timeout), 32'(c >= 4));
         chk("t4_if_valid", 32'(bus.if_valid), 32'(c == 5));
         @(negedge clk);
      end
      e_stall = e_stall + 5; e_if = e_if + 1;
      drive(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1);
      probe();
      chk("t4_err_sticky", 32'(err_timeout), 32'd1);
      chk_counts("t4");
      @(negedge clk);
      chk("t4_err_sticky2", 32'(err_timeout), 32'd1);

      // reset while the data access has been served and the fetch is pending
      drive(1'b1, 1'b0, 32'h0000_2004, '0, 1'b1, 32'h0000_010C, 1'b1);
      probe();
      chk("t5c0_addr", bus.mem_addr, 32'h0000_2004);
      chk("t5c0_pc_hold", 32'(pc_hold), 32'd1);
      @(negedge clk);
      reset = 1'b1;
      bus.mem_ready = 1'b0;
      probe();
      chk("t5r_mem_req", 32'(bus.mem_req), 32'd0);
      chk("t5r_pc_hold", 32'(pc_hold), 32'd0);
      chk("t5r_opts", opts(), 32'h00);
      chk("t5r_valids", {30'd0, bus.if_valid, bus.dm_valid}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      bus.mem_ready = 1'b1;
      e_stall = 0; e_dm = 0; e_if = 0;
      chk_counts("t5");
      chk("t5_err", 32'(err_timeout), 32'd0);
      // same requests again: the data access must be reissued first
      exp_dm_q.push_back(mem_fn(32'h0000_2004));
      exp_if_q.push_back(mem_fn(32'h0000_010C));
      probe();
      chk("t5c0b_addr", bus.mem_addr, 32'h0000_2004);
      chk("t5c0b_opts", opts(), 32'hA9);
      @(negedge clk);
      probe();
      chk("t5c1b_addr", bus.mem_addr, 32'h0000_010C);
      e_stall = e_stall + 1; e_dm = e_dm + 1; e_if = e_if + 1;
      @(negedge clk);
      drive(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
      chk_counts("t5b");

      // stall counter wraps at 2^32
      force dut.cnt_stall_q = 32'hFFFF_FFFF;
      #1;
      release dut.cnt_stall_q;
      chk("t6_preload", cnt_stall, 32'hFFFF_FFFF);
      drive(1'b1, 1'b0, 32'h0000_2008, '0, 1'b1, 32'h0000_0110, 1'b1);
      exp_dm_q.push_back(mem_fn(32'h0000_2008));
      exp_if_q.push_back(mem_fn(32'h0000_0110));
      probe();
      chk("t6c0_pc_hold", 32'(pc_hold), 32'd1);
      @(negedge clk);
      probe();
      chk("t6_wrap", cnt_stall, 32'd0);
      @(negedge clk);
      drive(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
      chk("t6_wrap_hold", cnt_stall, 32'd0);

      chk("if_q_drained", 32'(exp_if_q.size()), 32'd0);
      chk("dm_q_drained", 32'(exp_dm_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
